// File: rtl/io_command_queue.sv
// Command queue between an upstream issuer and the IO manager.
// Commands whose address falls outside the IO window are dropped and counted.
module io_command_queue #(
  parameter int DATABITWIDTH = 16,
  parameter int DEPTH        = 4,
  parameter int IOBASEADDR   = 384,
  parameter int IOWINDOW     = 128
) (
  input  logic                      sys_clk,
  input  logic                      clk_en,
  input  logic                      sync_rst,
  input  logic                      InACK,
  output logic                      InREQ,
  input  logic [3:0]                MinorOpcodeIn,
  input  logic [DATABITWIDTH-1:0]   AddressIn,
  input  logic [DATABITWIDTH-1:0]   DataIn,
  input  logic [3:0]                DestRegIn,
  output logic                      CommandACK,
  input  logic                      CommandREQ,
  output logic [3:0]                MinorOpcodeOut,
  output logic [DATABITWIDTH-1:0]   CommandAddressOut,
  output logic [DATABITWIDTH-1:0]   CommandDataOut,
  output logic [3:0]                CommandDestRegOut,
  input  logic                      Flush,
  output logic [$clog2(DEPTH):0]    Occupancy,
  output logic                      RangeFault,
  output logic [7:0]                FaultCount
);

  localparam int PTRW = $clog2(DEPTH);
  // One extra bit so the window upper bound never wraps.
  localparam logic [DATABITWIDTH:0] WINLO = (DATABITWIDTH+1)'(IOBASEADDR);
  localparam logic [DATABITWIDTH:0] WINHI = (DATABITWIDTH+1)'(IOBASEADDR + IOWINDOW - 1);

  logic [3:0]              opMem   [DEPTH];
  logic [DATABITWIDTH-1:0] addrMem [DEPTH];
  logic [DATABITWIDTH-1:0] dataMem [DEPTH];
  logic [3:0]              destMem [DEPTH];

  logic [PTRW-1:0]         headPtr;
  logic [PTRW-1:0]         tailPtr;
  logic [PTRW:0]           occupancy;
  logic                    rangeFault;
  logic [7:0]              faultCount;

  logic [DATABITWIDTH:0]   addrExt;
  logic                    inWindow;
  logic                    accept;
  logic                    store;
  logic                    drop;
  logic                    dequeue;

  assign addrExt  = {1'b0, AddressIn};
  assign inWindow = (addrExt >= WINLO) && (addrExt <= WINHI);

  assign CommandACK = (occupancy != '0);
  assign InREQ      = (occupancy < (PTRW+1)'(DEPTH)) && !Flush;
  assign accept     = InACK && InREQ && clk_en;
  assign store      = accept && inWindow;
  assign drop       = accept && !inWindow;
  assign dequeue    = CommandACK && CommandREQ && clk_en;

  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      headPtr    <= '0;
      tailPtr    <= '0;
      occupancy  <= '0;
      rangeFault <= 1'b0;
      faultCount <= '0;
    end else if (clk_en) begin
      rangeFault <= drop;
      if (drop && (faultCount != 8'hFF)) begin
        faultCount <= faultCount + 8'd1;
      end
      if (Flush) begin
        headPtr   <= '0;
        tailPtr   <= '0;
        occupancy <= '0;
      end else begin
        if (store) begin
          tailPtr <= tailPtr + PTRW'(1);
        end
        if (dequeue) begin
          headPtr <= headPtr + PTRW'(1);
        end
        case ({store, dequeue})
          2'b10:   occupancy <= occupancy + (PTRW+1)'(1);
          2'b01:   occupancy <= occupancy - (PTRW+1)'(1);
          default: occupancy <= occupancy;
        endcase
      end
    end
  end

  // Storage is not reset; store already implies no Flush.
  always_ff @(posedge sys_clk) begin
    if (!sync_rst && store) begin
      opMem[tailPtr]   <= MinorOpcodeIn;
      addrMem[tailPtr] <= AddressIn;
      dataMem[tailPtr] <= DataIn;
      destMem[tailPtr] <= DestRegIn;
    end
  end

  // Head outputs read zero whenever the queue is empty, which covers reset.
  assign MinorOpcodeOut    = CommandACK ? opMem[headPtr]   : '0;
  assign CommandAddressOut = CommandACK ? addrMem[headPtr] : '0;
  assign CommandDataOut    = CommandACK ? dataMem[headPtr] : '0;
  assign CommandDestRegOut = CommandACK ? destMem[headPtr] : '0;

  assign Occupancy  = occupancy;
  assign RangeFault = rangeFault;
  assign FaultCount = faultCount;

endmodule

// File: tb/tb_io_command_queue.sv
// Bench for io_command_queue: a queue scoreboard tracks expected contents,
// and each scenario task adds its own targeted checks.
module tb_io_command_queue;

  localparam int DEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        clk_en, sync_rst, InACK, InREQ, CommandACK, CommandREQ, Flush;
  logic [3:0]  MinorOpcodeIn, DestRegIn, MinorOpcodeOut, CommandDestRegOut;
  logic [15:0] AddressIn, DataIn, CommandAddressOut, CommandDataOut;
  logic [2:0]  Occupancy;
  logic        RangeFault;
  logic [7:0]  FaultCount;

  int checks = 0;
  int errors = 0;

  logic [39:0] sbQ [$];
  logic        modelValid = 1'b0;
  logic        expFault;
  int          expFaultCnt;
  logic        mFull, mAcc, mInWin;
  logic [39:0] headObs;

  io_command_queue #(.DATABITWIDTH(16), .DEPTH(DEPTH), .IOBASEADDR(384), .IOWINDOW(128)) dut (
    .sys_clk(sys_clk), .clk_en(clk_en), .sync_rst(sync_rst),
    .InACK(InACK), .InREQ(InREQ), .MinorOpcodeIn(MinorOpcodeIn),
    .AddressIn(AddressIn), .DataIn(DataIn), .DestRegIn(DestRegIn),
    .CommandACK(CommandACK), .CommandREQ(CommandREQ),
    .MinorOpcodeOut(MinorOpcodeOut), .CommandAddressOut(CommandAddressOut),
    .CommandDataOut(CommandDataOut), .CommandDestRegOut(CommandDestRegOut),
    .Flush(Flush), .Occupancy(Occupancy), .RangeFault(RangeFault), .FaultCount(FaultCount)
  );

  always #5 sys_clk = ~sys_clk;

  // Scoreboard: compare observed state on the falling edge, then predict the next rising edge.
  always @(negedge sys_clk) begin
    if (modelValid) begin
      checks++;
      if (Occupancy !== 3'(sbQ.size())) begin
        errors++; $display("FAIL sb_occupancy got %0d want %0d", Occupancy, sbQ.size());
      end
      checks++;
      if (InREQ !== ((sbQ.size() < DEPTH) && !Flush)) begin
        errors++; $display("FAIL sb_inreq got %0b want %0b", InREQ, (sbQ.size() < DEPTH) && !Flush);
      end
      checks++;
      if (CommandACK !== (sbQ.size() != 0)) begin
        errors++; $display("FAIL sb_cmdack got %0b want %0b", CommandACK, sbQ.size() != 0);
      end
      checks++;
      if (RangeFault !== expFault || FaultCount !== 8'(expFaultCnt)) begin
        errors++; $display("FAIL sb_fault got %0b/%0d want %0b/%0d", RangeFault, FaultCount, expFault, expFaultCnt);
      end
      if (sbQ.size() != 0) begin
        headObs = {MinorOpcodeOut, CommandAddressOut, CommandDataOut, CommandDestRegOut};
        checks++;
        if (headObs !== sbQ[0]) begin
          errors++; $display("FAIL sb_head got %h want %h", headObs, sbQ[0]);
        end
      end
    end
    if (sync_rst) begin
      sbQ.delete();
      expFault    = 1'b0;
      expFaultCnt = 0;
      modelValid  = 1'b1;
    end else if (clk_en && modelValid) begin
      mFull    = (sbQ.size() >= DEPTH);
      mAcc     = InACK && !mFull && !Flush;
      mInWin   = (AddressIn >= 16'd384) && (AddressIn <= 16'd511);
      expFault = mAcc && !mInWin;
      if (expFault && expFaultCnt != 255) expFaultCnt++;
      if (Flush) begin
        sbQ.delete();
      end else begin
        if (sbQ.size() != 0 && CommandREQ) void'(sbQ.pop_front());
        if (mAcc && mInWin) sbQ.push_back({MinorOpcodeIn, AddressIn, DataIn, DestRegIn});
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic setCmd(input logic [15:0] a, input logic [15:0] d, input logic [3:0] op, input logic [3:0] dest);
    InACK = 1'b1; AddressIn = a; DataIn = d; MinorOpcodeIn = op; DestRegIn = dest;
  endtask

  task automatic test_reset();
    sync_rst = 1'b1;
    tick(); tick();
    sync_rst = 1'b0;
    checks++;
    if ({Occupancy, CommandACK, RangeFault, FaultCount} !== 13'd0) begin
      errors++; $display("FAIL reset_state got occ=%0d ack=%0b rf=%0b fc=%0d want 0", Occupancy, CommandACK, RangeFault, FaultCount);
    end
    checks++;
    if ({CommandAddressOut, CommandDataOut, MinorOpcodeOut, CommandDestRegOut} !== 40'd0) begin
      errors++; $display("FAIL reset_head got %h/%h want 0", CommandAddressOut, CommandDataOut);
    end
  endtask

  task automatic test_hold();
    CommandREQ = 1'b0;
    setCmd(16'd390, 16'hBEEF, 4'h3, 4'd5);
    tick();
    InACK = 1'b0;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if ({CommandACK, CommandAddressOut, CommandDataOut, MinorOpcodeOut, CommandDestRegOut} !== {1'b1, 16'd390, 16'hBEEF, 4'h3, 4'd5}) begin
        errors++; $display("FAIL hold_stable cycle %0d got ack=%0b %0d/%h/%0d/%0d want 1 390/beef/3/5", i, CommandACK,
                           CommandAddressOut, CommandDataOut, MinorOpcodeOut, CommandDestRegOut);
      end
      if (i < 10) tick();
    end
    CommandREQ = 1'b1;
    tick();
    CommandREQ = 1'b0;
    checks++;
    if (Occupancy !== 3'd0 || CommandACK !== 1'b0) begin
      errors++; $display("FAIL hold_dequeue got occ=%0d ack=%0b want 0/0", Occupancy, CommandACK);
    end
  endtask

  task automatic test_full();
    CommandREQ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      setCmd(16'(400 + i), 16'(16'h100 + i), 4'(i), 4'(i));
      tick();
      if (i == 3) begin
        checks++;
        if (InREQ !== 1'b0 || Occupancy !== 3'd4) begin
          errors++; $display("FAIL full_after4 got inreq=%0b occ=%0d want 0/4", InREQ, Occupancy);
        end
      end
    end
    InACK = 1'b0;
    checks++;
    if (Occupancy !== 3'd4) begin
      errors++; $display("FAIL full_occ got %0d want 4", Occupancy);
    end
    CommandREQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (CommandDataOut !== 16'(16'h100 + i)) begin
        errors++; $display("FAIL full_order %0d got %h want %h", i, CommandDataOut, 16'h100 + i);
      end
      tick();
    end
    CommandREQ = 1'b0;
    checks++;
    if (Occupancy !== 3'd0) begin
      errors++; $display("FAIL full_drain got %0d want 0", Occupancy);
    end
  endtask

  task automatic test_window();
    CommandREQ = 1'b0;
    setCmd(16'd383, 16'h1, 4'h1, 4'd1);
    tick();
    InACK = 1'b0;
    checks++;
    if (RangeFault !== 1'b1 || FaultCount !== 8'd1 || Occupancy !== 3'd0) begin
      errors++; $display("FAIL window_383 got rf=%0b fc=%0d occ=%0d want 1/1/0", RangeFault, FaultCount, Occupancy);
    end
    tick();
    checks++;
    if (RangeFault !== 1'b0) begin
      errors++; $display("FAIL window_pulse_width got %0b want 0", RangeFault);
    end
    setCmd(16'd512, 16'h2, 4'h2, 4'd2);
    tick();
    checks++;
    if (RangeFault !== 1'b1 || FaultCount !== 8'd2) begin
      errors++; $display("FAIL window_512 got rf=%0b fc=%0d want 1/2", RangeFault, FaultCount);
    end
    setCmd(16'd384, 16'h3, 4'h3, 4'd3);
    tick();
    setCmd(16'd511, 16'h4, 4'h4, 4'd4);
    tick();
    InACK = 1'b0;
    checks++;
    if (Occupancy !== 3'd2 || RangeFault !== 1'b0 || FaultCount !== 8'd2) begin
      errors++; $display("FAIL window_edges got occ=%0d rf=%0b fc=%0d want 2/0/2", Occupancy, RangeFault, FaultCount);
    end
    CommandREQ = 1'b1;
    checks++;
    if (CommandAddressOut !== 16'd384) begin
      errors++; $display("FAIL window_head384 got %0d want 384", CommandAddressOut);
    end
    tick();
    checks++;
    if (CommandAddressOut !== 16'd511) begin
      errors++; $display("FAIL window_head511 got %0d want 511", CommandAddressOut);
    end
    tick();
    CommandREQ = 1'b0;
  endtask

  task automatic test_clk_en();
    CommandREQ = 1'b0;
    setCmd(16'd100, 16'h9, 4'h9, 4'd9);
    tick();
    clk_en = 1'b0;
    setCmd(16'd400, 16'h55, 4'h5, 4'd5);
    CommandREQ = 1'b1;
    repeat (3) tick();
    checks++;
    if (RangeFault !== 1'b1 || FaultCount !== 8'd3 || Occupancy !== 3'd0) begin
      errors++; $display("FAIL clken_hold_fault got rf=%0b fc=%0d occ=%0d want 1/3/0", RangeFault, FaultCount, Occupancy);
    end
    clk_en = 1'b1;
    tick();
    InACK = 1'b0;
    CommandREQ = 1'b0;
    checks++;
    if (RangeFault !== 1'b0 || Occupancy !== 3'd1) begin
      errors++; $display("FAIL clken_resume got rf=%0b occ=%0d want 0/1", RangeFault, Occupancy);
    end
    clk_en = 1'b0;
    CommandREQ = 1'b1;
    repeat (3) tick();
    checks++;
    if (Occupancy !== 3'd1) begin
      errors++; $display("FAIL clken_hold_deq got %0d want 1", Occupancy);
    end
    clk_en = 1'b1;
    tick();
    CommandREQ = 1'b0;
    checks++;
    if (Occupancy !== 3'd0) begin
      errors++; $display("FAIL clken_deq got %0d want 0", Occupancy);
    end
  endtask

  task automatic test_streaming();
    CommandREQ = 1'b0;
    setCmd(16'd420, 16'h200, 4'h0, 4'd0);
    tick();
    CommandREQ = 1'b1;
    for (int i = 0; i < 20; i++) begin
      setCmd(16'(421 + i), 16'(16'h201 + i), 4'(i), 4'(i + 1));
      tick();
      checks++;
      if (Occupancy !== 3'd1 || CommandDataOut !== 16'(16'h201 + i)) begin
        errors++; $display("FAIL stream %0d got occ=%0d data=%h want 1/%h", i, Occupancy, CommandDataOut, 16'h201 + i);
      end
    end
    InACK = 1'b0;
    tick();
    CommandREQ = 1'b0;
    checks++;
    if (Occupancy !== 3'd0) begin
      errors++; $display("FAIL stream_drain got %0d want 0", Occupancy);
    end
  endtask

  task automatic test_flush();
    CommandREQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setCmd(16'(430 + i), 16'(16'h300 + i), 4'h1, 4'd1);
      tick();
    end
    InACK = 1'b0;
    Flush = 1'b1;
    CommandREQ = 1'b1;
    #1;
    checks++;
    if (Occupancy !== 3'd3 || InREQ !== 1'b0) begin
      errors++; $display("FAIL flush_pre got occ=%0d inreq=%0b want 3/0", Occupancy, InREQ);
    end
    tick();
    Flush = 1'b0;
    CommandREQ = 1'b0;
    checks++;
    if (Occupancy !== 3'd0 || CommandACK !== 1'b0 || FaultCount !== 8'd3) begin
      errors++; $display("FAIL flush_post got occ=%0d ack=%0b fc=%0d want 0/0/3", Occupancy, CommandACK, FaultCount);
    end
    setCmd(16'd450, 16'hCAFE, 4'h7, 4'd7);
    tick();
    InACK = 1'b0;
    checks++;
    if (CommandACK !== 1'b1 || CommandDataOut !== 16'hCAFE) begin
      errors++; $display("FAIL flush_reuse got ack=%0b data=%h want 1/cafe", CommandACK, CommandDataOut);
    end
    CommandREQ = 1'b1;
    tick();
    CommandREQ = 1'b0;
  endtask

  task automatic test_saturate();
    CommandREQ = 1'b0;
    setCmd(16'd450, 16'h77, 4'h2, 4'd2);
    tick();
    setCmd(16'd0, 16'h0, 4'h0, 4'd0);
    repeat (300) tick();
    InACK = 1'b0;
    checks++;
    if (FaultCount !== 8'd255 || RangeFault !== 1'b1 || Occupancy !== 3'd1) begin
      errors++; $display("FAIL sat_count got fc=%0d rf=%0b occ=%0d want 255/1/1", FaultCount, RangeFault, Occupancy);
    end
    tick();
    checks++;
    if (FaultCount !== 8'd255 || RangeFault !== 1'b0) begin
      errors++; $display("FAIL sat_hold got fc=%0d rf=%0b want 255/0", FaultCount, RangeFault);
    end
    sync_rst = 1'b1;
    clk_en = 1'b0;
    Flush = 1'b1;
    CommandREQ = 1'b1;
    setCmd(16'd460, 16'h88, 4'h3, 4'd3);
    tick();
    checks++;
    if ({Occupancy, CommandACK, RangeFault, FaultCount} !== 13'd0 || CommandDataOut !== 16'd0) begin
      errors++; $display("FAIL sat_reset got occ=%0d ack=%0b rf=%0b fc=%0d data=%h want 0", Occupancy, CommandACK,
                         RangeFault, FaultCount, CommandDataOut);
    end
    sync_rst = 1'b0;
    clk_en = 1'b1;
    Flush = 1'b0;
    CommandREQ = 1'b0;
    InACK = 1'b0;
    tick();
    checks++;
    if (Occupancy !== 3'd0 || FaultCount !== 8'd0) begin
      errors++; $display("FAIL reset_lost_cmd got occ=%0d fc=%0d want 0/0", Occupancy, FaultCount);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clk_en = 1'b1; sync_rst = 1'b1; InACK = 1'b0; CommandREQ = 1'b0; Flush = 1'b0;
    MinorOpcodeIn = '0; AddressIn = '0; DataIn = '0; DestRegIn = '0;
    test_reset();
    test_hold();
    test_full();
    test_window();
    test_clk_en();
    test_streaming();
    test_flush();
    test_saturate();
    @(negedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_command_queue.md
IO_COMMAND_QUEUE -- requirements
Module: io_command_queue

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATABITWIDTH, 16, address and data width.
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- IOBASEADDR, 384, first valid IO address.
- IOWINDOW, 128, count of valid IO addresses starting at IOBASEADDR.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- sys_clk, in, 1, sole clock.
- clk_en, in, 1, global clock enable.
- sync_rst, in, 1, reset; synchronous, active-high.
- InACK, in, 1, upstream command valid.
- InREQ, out, 1, queue ready to accept.
- MinorOpcodeIn, in, 4, command opcode.
- AddressIn, in, DATABITWIDTH, absolute IO address.
- DataIn, in, DATABITWIDTH, command data.
- DestRegIn, in, 4, writeback register.
- CommandACK, out, 1, head entry valid toward IO manager.
- CommandREQ, in, 1, IO manager ready.
- MinorOpcodeOut, out, 4, head opcode.
- CommandAddressOut, out, DATABITWIDTH, head address.
- CommandDataOut, out, DATABITWIDTH, head data.
- CommandDestRegOut, out, 4, head destination register.
- Flush, in, 1, discard all queued entries.
- Occupancy, out, $clog2(DEPTH)+1, number of valid entries.
- RangeFault, out, 1, one-cycle pulse after an out-of-window command is dropped.
- FaultCount, out, 8, saturating count of dropped commands.

Function
REQ-003 All state SHALL update only on rising sys_clk edges with clk_en=1; with clk_en=0 every register SHALL hold its value.
REQ-004 InREQ SHALL equal (Occupancy<DEPTH) AND NOT Flush; it SHALL be combinational from registered state and Flush only.
REQ-005 An accept SHALL occur when InACK=1, InREQ=1 and clk_en=1.
REQ-006 An accepted command with IOBASEADDR <= AddressIn <= IOBASEADDR+IOWINDOW-1 SHALL be written at the tail pointer, advancing the tail pointer mod DEPTH.
REQ-007 An accepted command outside the window SHALL be consumed but not stored. RangeFault SHALL be 1 for exactly the next enabled cycle. FaultCount SHALL increment and saturate at 255.
REQ-008 The window compare SHALL use DATABITWIDTH+1-bit unsigned arithmetic so that IOBASEADDR+IOWINDOW-1 cannot wrap.
REQ-009 CommandACK SHALL equal (Occupancy!=0).
REQ-010 The head outputs SHALL come from the entry at the head pointer, with no combinational path from In* inputs.
REQ-011 An empty queue SHALL give 1-cycle latency: a command accepted at edge N SHALL be visible at CommandACK after edge N.
REQ-012 A dequeue SHALL occur when CommandACK=1, CommandREQ=1 and clk_en=1. It SHALL advance the head pointer mod DEPTH.
REQ-013 While CommandACK=1 and CommandREQ=0, the head outputs SHALL remain stable.
REQ-014 A simultaneous in-window enqueue and dequeue SHALL leave Occupancy unchanged. Both pointers SHALL advance.
REQ-015 When the queue is full, InREQ SHALL be 0 even if a dequeue occurs in the same cycle; there is no full-bypass path.
REQ-016 Flush=1 on an enabled edge SHALL set Occupancy, the head pointer and the tail pointer to 0.
REQ-017 Flush SHALL override any same-cycle dequeue.
REQ-018 Flush SHALL NOT clear FaultCount, and SHALL NOT suppress a RangeFault pulse already scheduled.
REQ-019 The pointer, Occupancy and FaultCount arithmetic SHALL be exact at the wrap points: pointers DEPTH-1 -> 0, Occupancy 0 <-> DEPTH, and FaultCount 255 -> 255.

Reset
REQ-020 sync_rst=1 on a sys_clk edge SHALL clear all state regardless of clk_en: Occupancy=0, pointers=0, CommandACK=0, RangeFault=0, FaultCount=0.
REQ-021 Head data outputs after reset SHALL be 0, and storage contents need not be reset.
REQ-022 Reset SHALL override Flush and any handshake in the same cycle. A command in flight at reset SHALL be lost, with no fault recorded.

Verification
REQ-023 Enqueue addr 390, data 0xBEEF, op 0x3, dest 5, with CommandREQ=0 -> the next cycle shows CommandACK=1 with outputs 390/0xBEEF/3/5, held stable for 10 cycles, then dequeued when CommandREQ=1.
REQ-024 Enqueue 5 back-to-back in-window commands with CommandREQ=0 -> 4 are accepted, InREQ=0 after the 4th, Occupancy=4; raising CommandREQ drains them in order.
REQ-025 Enqueue addr 383 and addr 512 -> each is dropped, giving two RangeFault pulses and FaultCount=2; addrs 384 and 511 are accepted.
REQ-026 Run continuous enqueue and dequeue for 20 cycles -> Occupancy stays at 1 and data order is preserved across pointer wrap.
REQ-027 Assert Flush at Occupancy=3 with CommandREQ=1 -> Occupancy=0 and CommandACK=0 next cycle, with no dequeue counted.
REQ-028 Drop 300 out-of-window commands -> FaultCount=255; then assert sync_rst -> FaultCount=0 and Occupancy=0.
